// File: rtl/hld_pkg.sv
// Shared types and parameter defaults for the multi-channel hold generator.
package hld_pkg;

    localparam int unsigned NUM_CH_DEF      = 2;
    localparam int unsigned CNT_W_DEF       = 4;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_HOLD = 1'b1
    } ch_state_t;

endpackage

// File: rtl/hld_channel.sv
// One hold channel: IDLE/HOLD FSM with a down counter that sets the pulse width.
module hld_channel
    import hld_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_ext,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             hld,
    output logic             busy
);

    ch_state_t        r_state;
    ch_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Length is captured at start so later len changes leave this hold untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                CH_IDLE: begin
                    if (start) begin
                        w_state_nxt = CH_HOLD;
                        w_cnt_nxt   = len;
                    end
                end
                CH_HOLD: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = CH_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = CH_IDLE;
            endcase
        end
    end

    assign hld  = (r_state == CH_HOLD);
    assign busy = (r_state == CH_HOLD);

endmodule

// File: rtl/hld_gen_mc.sv
// Multi-channel hold generator: synchronises div_m/div_n, spreads div_m edges
// round-robin over hold channels and drives reset_pd with harmonic compensation.
module hld_gen_mc
    import hld_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sel,
    input  logic              div_m,
    input  logic              div_n,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              harm_en,
    input  logic              ovr_clr,
    output logic [NUM_CH-1:0] hld,
    output logic              reset_pd,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [SYNC_STAGES-1:0] r_sync_m;
    logic [SYNC_STAGES-1:0] r_sync_n;
    logic                   r_dly_m;
    logic                   r_dly_n;
    logic                   w_s_m;
    logic                   w_s_n;
    logic                   w_rise_m;
    logic                   w_rise_n;
    logic                   w_fall_n;

    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_pick;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic              w_found;
    logic              w_ev;
    logic              w_go;
    logic              w_drop;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_hld;
    logic [NUM_CH-1:0] w_busy;

    logic r_overrun;
    logic r_harm_hold;
    logic r_harm_flag;

    // Plain flop chains; the extra delay flop gives the edge detectors.
    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_m <= '0;
            r_sync_n <= '0;
            r_dly_m  <= 1'b0;
            r_dly_n  <= 1'b0;
        end else begin
            r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], div_m};
            r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], div_n};
            r_dly_m  <= r_sync_m[SYNC_STAGES-1];
            r_dly_n  <= r_sync_n[SYNC_STAGES-1];
        end
    end

    assign w_s_m    = r_sync_m[SYNC_STAGES-1];
    assign w_s_n    = r_sync_n[SYNC_STAGES-1];
    assign w_rise_m = w_s_m & ~r_dly_m;
    assign w_rise_n = w_s_n & ~r_dly_n;
    assign w_fall_n = ~w_s_n & r_dly_n;

    assign w_elig = ch_mask & ~w_busy;

    // Downward scan so the last hit is the first eligible channel at or after r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            if (w_elig[PTR_W'((int'(r_ptr) + k) % int'(NUM_CH))]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((int'(r_ptr) + k) % int'(NUM_CH));
            end
        end
    end

    assign w_ptr_nxt = (32'(w_pick) == NUM_CH - 1) ? '0 : w_pick + 1'b1;
    assign w_ev      = en & sel & w_rise_m;
    assign w_go      = w_ev & w_found;
    assign w_drop    = w_ev & ~w_found;

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_overrun   <= 1'b0;
            r_harm_hold <= 1'b0;
            r_harm_flag <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (!en) begin
                r_ptr       <= '0;
                r_harm_hold <= 1'b0;
                r_harm_flag <= 1'b0;
            end else begin
                if (w_go) begin
                    r_ptr <= w_ptr_nxt;
                end
                if (w_fall_n) begin
                    r_harm_flag <= w_s_m;
                end
                if (!harm_en) begin
                    r_harm_hold <= 1'b0;
                end else if (w_rise_n) begin
                    r_harm_hold <= w_s_m | r_harm_flag;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_start[g] = w_go && (w_pick == PTR_W'(g));

        hld_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_ext (clk_ext),
            .rst_n   (rst_n),
            .clr     (~en),
            .start   (w_start[g]),
            .len     (hold_len),
            .hld     (w_hld[g]),
            .busy    (w_busy[g])
        );
    end

    assign hld      = w_hld;
    assign reset_pd = (|w_hld) | r_harm_hold;
    assign busy     = |w_busy;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_hld_gen_mc.sv
// Self-checking bench for hld_gen_mc: vector table with a hold scoreboard plus
// hand-written latency, overrun, harmonic, enable and reset sequences.
module tb_hld_gen_mc;

    localparam int unsigned NCH = 2;
    localparam int unsigned CW  = 4;

    logic           clk_ext = 1'b0;
    logic           rst_n;
    logic           en;
    logic           sel;
    logic           div_m;
    logic           div_n;
    logic [CW-1:0]  hold_len;
    logic [NCH-1:0] ch_mask;
    logic           harm_en;
    logic           ovr_clr;
    logic [NCH-1:0] hld;
    logic           reset_pd;
    logic           busy;
    logic           overrun;

    hld_gen_mc #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk_ext  (clk_ext),
        .rst_n    (rst_n),
        .en       (en),
        .sel      (sel),
        .div_m    (div_m),
        .div_n    (div_n),
        .hold_len (hold_len),
        .ch_mask  (ch_mask),
        .harm_en  (harm_en),
        .ovr_clr  (ovr_clr),
        .hld      (hld),
        .reset_pd (reset_pd),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk_ext = ~clk_ext;

    typedef struct {
        int ch;
        int w;
    } sb_t;

    // ch nibble i = channel expected for rise i, 4'hF = no hold expected
    typedef struct {
        int unsigned    len;
        logic [1:0]     mask;
        logic           sel;
        int unsigned    hi;
        int unsigned    lo;
        int unsigned    n;
        logic [3:0][3:0] ch;
        logic           ovr;
    } vec_t;

    sb_t  sbq[$];
    sb_t  e;
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic [NCH-1:0] prev = '0;
    int   run_len[NCH];
    int   exp_w[NCH];
    vec_t vt[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_ext);
        #2;
    endtask

    // Scoreboard consumer: every hold start pops one entry; every hold end checks width.
    always @(negedge clk_ext) begin
        for (int c = 0; c < int'(NCH); c++) begin
            if (mon_en) begin
                if (hld[c] && !prev[c]) begin
                    n_vec++;
                    run_len[c] = 1;
                    if (sbq.size() == 0) begin
                        n_err++;
                        exp_w[c] = 0;
                        $display("FAIL hold_start ch%0d: got unexpected hold, expected none", c);
                    end else begin
                        e = sbq.pop_front();
                        exp_w[c] = e.w;
                        if (e.ch != c) begin
                            n_err++;
                            $display("FAIL hold_chan: got ch%0d expected ch%0d", c, e.ch);
                        end
                    end
                end else if (hld[c]) begin
                    run_len[c]++;
                end
                if (!hld[c] && prev[c]) begin
                    n_vec++;
                    if (run_len[c] != exp_w[c]) begin
                        n_err++;
                        $display("FAIL hold_width ch%0d: got %0d expected %0d", c, run_len[c], exp_w[c]);
                    end
                end
            end
            prev[c] = hld[c];
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; sel = 1'b0; div_m = 1'b0; div_n = 1'b0;
        hold_len = '0; ch_mask = '0; harm_en = 1'b0; ovr_clr = 1'b0;

        vt[0] = '{3,  2'b11, 1'b1, 2, 8, 1, 16'hFFF0, 1'b0};
        vt[1] = '{3,  2'b11, 1'b1, 2, 8, 3, 16'hF010, 1'b0};
        vt[2] = '{15, 2'b11, 1'b1, 2, 2, 3, 16'hFF10, 1'b1};
        vt[3] = '{2,  2'b10, 1'b1, 2, 6, 3, 16'hF111, 1'b0};
        vt[4] = '{2,  2'b11, 1'b0, 2, 6, 2, 16'hFFFF, 1'b0};
        vt[5] = '{2,  2'b00, 1'b1, 2, 6, 1, 16'hFFFF, 1'b1};
        vt[6] = '{0,  2'b11, 1'b1, 2, 2, 4, 16'h1010, 1'b0};
        vt[7] = '{7,  2'b01, 1'b1, 2, 2, 2, 16'hFFF0, 1'b1};

        #12;
        chk("rst_hld", 32'(hld), 32'h0);
        chk("rst_reset_pd", 32'(reset_pd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc(3);

        // Latency: first high sample at edge k, hold visible after edge k+2.
        hold_len = 4'd3; ch_mask = 2'b11; sel = 1'b1;
        cyc(1);
        sbq.push_back('{0, 4});
        div_m = 1'b1;
        @(posedge clk_ext); #1;
        chk("lat_k", 32'(hld), 32'h0);
        @(posedge clk_ext); #1;
        chk("lat_k1", 32'(hld), 32'h0);
        @(posedge clk_ext); #1;
        chk("lat_k2_hld", 32'(hld), 32'h1);
        chk("lat_k2_reset_pd", 32'(reset_pd), 32'h1);
        chk("lat_k2_busy", 32'(busy), 32'h1);
        #1 div_m = 1'b0;
        cyc(10);
        en = 1'b0;
        cyc(1);
        en = 1'b1;

        // Table-driven vectors; en pulse between them returns the pointer to 0.
        for (int i = 0; i < 8; i++) begin
            hold_len = CW'(vt[i].len);
            ch_mask  = vt[i].mask;
            sel      = vt[i].sel;
            cyc(2);
            for (int r = 0; r < int'(vt[i].n); r++) begin
                if (vt[i].ch[r] != 4'hF) sbq.push_back('{int'(vt[i].ch[r]), int'(vt[i].len) + 1});
                div_m = 1'b1;
                cyc(int'(vt[i].hi));
                div_m = 1'b0;
                cyc(int'(vt[i].lo));
            end
            cyc(30);
            chk($sformatf("v%0d_pending", i), 32'(sbq.size()), 32'h0);
            chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'(vt[i].ovr));
            ovr_clr = 1'b1;
            en = 1'b0;
            cyc(1);
            ovr_clr = 1'b0;
            en = 1'b1;
            chk($sformatf("v%0d_ovr_clr", i), 32'(overrun), 32'h0);
            sbq.delete();
        end

        // Overrun set and clear in the same cycle: set wins, clear takes effect next edge.
        ch_mask = 2'b00; sel = 1'b1; ovr_clr = 1'b1;
        cyc(1);
        div_m = 1'b1;
        @(posedge clk_ext); #1;
        @(posedge clk_ext); #1;
        chk("ovr_both_pre", 32'(overrun), 32'h0);
        @(posedge clk_ext); #1;
        chk("ovr_both_set", 32'(overrun), 32'h1);
        @(posedge clk_ext); #1;
        chk("ovr_both_clr", 32'(overrun), 32'h0);
        ovr_clr = 1'b0; div_m = 1'b0;
        cyc(4);

        // Harmonic compensation with no channel activity.
        sel = 1'b0; harm_en = 1'b1;
        div_n = 1'b1; cyc(6);
        chk("harm_idle", 32'(reset_pd), 32'h0);
        div_m = 1'b1; cyc(6);
        div_n = 1'b0; cyc(6);
        div_m = 1'b0; cyc(6);
        div_n = 1'b1; cyc(6);
        chk("harm_set_reset_pd", 32'(reset_pd), 32'h1);
        chk("harm_set_hld", 32'(hld), 32'h0);
        chk("harm_set_busy", 32'(busy), 32'h0);
        div_n = 1'b0; cyc(6);
        div_n = 1'b1; cyc(6);
        chk("harm_release", 32'(reset_pd), 32'h0);
        div_m = 1'b1; cyc(6);
        div_n = 1'b0; cyc(6);
        div_n = 1'b1; cyc(6);
        chk("harm_set2", 32'(reset_pd), 32'h1);
        harm_en = 1'b0;
        @(posedge clk_ext); #1;
        chk("harm_en_off", 32'(reset_pd), 32'h0);
        div_m = 1'b0; div_n = 1'b0;
        cyc(6);

        // en=0 mid-hold: channels clear next edge, overrun kept.
        mon_en = 1'b0;
        hold_len = 4'd15; ch_mask = 2'b01; sel = 1'b1;
        cyc(1);
        div_m = 1'b1; cyc(2); div_m = 1'b0; cyc(2);
        div_m = 1'b1; cyc(2); div_m = 1'b0; cyc(4);
        chk("en_pre_hld", 32'(hld), 32'h1);
        chk("en_pre_ovr", 32'(overrun), 32'h1);
        en = 1'b0;
        @(posedge clk_ext); #1;
        chk("en_off_hld", 32'(hld), 32'h0);
        chk("en_off_busy", 32'(busy), 32'h0);
        chk("en_off_ovr", 32'(overrun), 32'h1);
        cyc(1);
        en = 1'b1;
        cyc(3);

        // Asynchronous reset mid-hold.
        ch_mask = 2'b11;
        div_m = 1'b1; cyc(2); div_m = 1'b0; cyc(3);
        chk("rst_pre_hld", 32'(hld), 32'h1);
        @(posedge clk_ext); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_hld", 32'(hld), 32'h0);
        chk("rst_mid_reset_pd", 32'(reset_pd), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_ovr", 32'(overrun), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
